mips_multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle MIPS core.
- Sequences instruction fetch, decode, execute, memory access and writeback over the shared ALU, register file and unified memory.
- Drives the 6-bit ALUOp bus consumed by the ALU function decoder.
- Memory access uses a ready handshake, so fetch and load/store states stall for wait states.

---
 rtl/mips_multicycle_ctrl_if.sv | 31 +++
 rtl/mips_multicycle_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl_if
// Purpose  : Unified-memory port between the multi-cycle control FSM (master)
//            and the memory (slave): address select, strobes and ready.
// Revision : 1.0
// ============================================================================
interface mips_multicycle_ctrl_if;
    logic i_or_d;
    logic mem_read;
    logic mem_write;
    logic mem_byte;
    logic mem_ready;

    modport master (
        output i_or_d,
        output mem_read,
        output mem_write,
        output mem_byte,
        input  mem_ready
    );

    modport slave (
        input  i_or_d,
        input  mem_read,
        input  mem_write,
        input  mem_byte,
        output mem_ready
    );
endinterface
`default_nettype wire

// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mips_multicycle_ctrl
// Purpose  : Main control FSM of the multi-cycle MIPS core. Define
//            MIPS_CTRL_JUMP_EN to decode j (000010) into the JUMP state.
// Revision : 1.0
// ============================================================================
module mips_multicycle_ctrl #(
    parameter logic [5:0] ADD_OP = 6'b001000,
    parameter logic [5:0] SUB_OP = 6'b000100
) (
    input  wire                    clk,
    input  wire                    rst,
    input  wire  [5:0]             opcode,
    input  wire                    zero,
    mips_multicycle_ctrl_if.master mem,
    output logic [5:0]             alu_op,
    output logic                   alu_src_a,
    output logic [1:0]             alu_src_b,
    output logic                   pc_en,
    output logic [1:0]             pc_source,
    output logic                   ir_write,
    output logic                   reg_write,
    output logic                   reg_dst,
    output logic                   mem_to_reg,
    output logic                   illegal_op,
    output logic [3:0]             state
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        I_EXEC    = 4'd9,
        I_WB      = 4'd10,
        JUMP      = 4'd11
    } state_e;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_LB    = 6'b100000;
    localparam logic [5:0] c_OP_SB    = 6'b101000;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;
    localparam logic [5:0] c_OP_ANDI  = 6'b001100;
    localparam logic [5:0] c_OP_ORI   = 6'b001101;
    localparam logic [5:0] c_OP_SLTI  = 6'b001010;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
`ifdef MIPS_CTRL_JUMP_EN
    localparam logic [5:0] c_OP_J     = 6'b000010;
`endif

    state_e     r_state;
    state_e     w_next_state;
    logic [5:0] r_opcode;
    logic       w_is_beq;
    logic       w_is_bne;
    logic       w_is_store;

    // The IR may change after DECODE; every later state works from this copy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= FETCH;
            r_opcode <= '0;
        end else begin
            r_state <= w_next_state;
            if (r_state == DECODE) begin
                r_opcode <= opcode;
            end
        end
    end

    assign w_is_beq   = (r_opcode == c_OP_BEQ);
    assign w_is_bne   = (r_opcode == c_OP_BNE);
    assign w_is_store = (r_opcode == c_OP_SW) || (r_opcode == c_OP_SB);
    assign state      = r_state;

    always_comb begin
        w_next_state  = FETCH;
        alu_op        = ADD_OP;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        pc_en         = 1'b0;
        pc_source     = 2'b00;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        illegal_op    = 1'b0;
        mem.i_or_d    = 1'b0;
        mem.mem_read  = 1'b0;
        mem.mem_write = 1'b0;
        mem.mem_byte  = 1'b0;

        case (r_state)
            FETCH: begin
                mem.mem_read = 1'b1;
                alu_src_b    = 2'b01;
                if (mem.mem_ready) begin
                    ir_write     = 1'b1;
                    pc_en        = 1'b1;
                    w_next_state = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    c_OP_RTYPE:                         w_next_state = R_EXEC;
                    c_OP_LW, c_OP_SW, c_OP_LB, c_OP_SB: w_next_state = MEM_ADDR;
                    c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_SLTI:
                                                        w_next_state = I_EXEC;
                    c_OP_BEQ, c_OP_BNE:                 w_next_state = BRANCH;
`ifdef MIPS_CTRL_JUMP_EN
                    c_OP_J:                             w_next_state = JUMP;
`endif
                    default:                            illegal_op   = 1'b1;
                endcase
            end
            MEM_ADDR: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                alu_op       = r_opcode;
                w_next_state = w_is_store ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                mem.mem_read = 1'b1;
                mem.i_or_d   = 1'b1;
                mem.mem_byte = (r_opcode == c_OP_LB);
                w_next_state = mem.mem_ready ? MEM_WB : MEM_READ;
            end
            MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            MEM_WRITE: begin
                mem.mem_write = 1'b1;
                mem.i_or_d    = 1'b1;
                mem.mem_byte  = (r_opcode == c_OP_SB);
                w_next_state  = mem.mem_ready ? FETCH : MEM_WRITE;
            end
            R_EXEC: begin
                alu_src_a    = 1'b1;
                alu_op       = 6'b000000;
                w_next_state = R_WB;
            end
            R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            BRANCH: begin
                // beq maps onto the SUB code; bne passes its own opcode through.
                alu_src_a = 1'b1;
                alu_op    = w_is_beq ? SUB_OP : r_opcode;
                pc_source = 2'b01;
                pc_en     = (zero & w_is_beq) | (~zero & w_is_bne);
            end
            I_EXEC: begin
                alu_src_a    = 1'b1;
                alu_src_b    = 2'b10;
                alu_op       = r_opcode;
                w_next_state = I_WB;
            end
            I_WB: begin
                reg_write = 1'b1;
            end
`ifdef MIPS_CTRL_JUMP_EN
            JUMP: begin
                pc_en     = 1'b1;
                pc_source = 2'b10;
            end
`endif
            default: begin
                w_next_state = FETCH;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_mips_multicycle_ctrl.sv
`default_nettype none
// Bench for mips_multicycle_ctrl: directed instruction table, asynchronous
// reset aborts, and random instruction streams against a cycle-trace model.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic [5:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal_op;
    logic [3:0] state;

    mips_multicycle_ctrl_if mem_bus ();

    mips_multicycle_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .mem        (mem_bus),
        .alu_op     (alu_op),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .pc_en      (pc_en),
        .pc_source  (pc_source),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal_op (illegal_op),
        .state      (state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [5:0] alu_op;
        logic       src_a;
        logic [1:0] src_b;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       i_or_d;
        logic       rd;
        logic       wr;
        logic       byt;
        logic       irw;
        logic       rw;
        logic       rdst;
        logic       m2r;
        logic       ill;
        logic [3:0] st;
    } outv_t;

    typedef struct packed {
        logic       rdy;
        logic       z;
        logic [5:0] opc;
        outv_t      e;
    } cyc_t;

    typedef struct {
        logic [5:0] opc;
        logic       z;
        int         wf;
        int         wm;
        int         cyc;
        int         nrw;
        int         nmw;
        int         npc;
        int         nill;
    } vec_t;

    localparam int c_R = 0, c_LD = 1, c_ST = 2, c_IMM = 3, c_BR = 4, c_J = 5, c_ILL = 6;

    outv_t      got;
    cyc_t       q[$];
    int         n_cmp  = 0;
    int         n_fail = 0;
    vec_t       vecs[15];
    logic [5:0] ops[14];

    always_comb got = {alu_op, alu_src_a, alu_src_b, pc_en, pc_source,
                       mem_bus.i_or_d, mem_bus.mem_read, mem_bus.mem_write, mem_bus.mem_byte,
                       ir_write, reg_write, reg_dst, mem_to_reg, illegal_op, state};

    task automatic chk(input string nm, input logic [31:0] g, input logic [31:0] x);
        n_cmp++;
        if (g !== x) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, g, x, $time);
        end
    endtask

    function automatic int cls(input logic [5:0] o);
        case (o)
            6'b000000:                                  return c_R;
            6'b100011, 6'b100000:                       return c_LD;
            6'b101011, 6'b101000:                       return c_ST;
            6'b001000, 6'b001100, 6'b001101, 6'b001010: return c_IMM;
            6'b000100, 6'b000101:                       return c_BR;
`ifdef MIPS_CTRL_JUMP_EN
            6'b000010:                                  return c_J;
`endif
            default:                                    return c_ILL;
        endcase
    endfunction

    function automatic outv_t base(input logic [3:0] st);
        outv_t e = '0;
        e.alu_op = 6'b001000;
        e.st     = st;
        return e;
    endfunction

    function automatic void add(input outv_t e, input logic rdy, input logic [5:0] opc, input logic z);
        cyc_t c;
        c.e = e; c.rdy = rdy; c.opc = opc; c.z = z;
        q.push_back(c);
    endfunction

    // Inputs that the current cycle must ignore are randomised.
    function automatic void add_any(input outv_t e);
        add(e, 1'($urandom), 6'($urandom), 1'($urandom));
    endfunction

    // Expand one instruction into its expected per-cycle trace.
    task automatic build(input logic [5:0] o, input int wf, input int wm);
        outv_t e;
        int    k;
        logic  z;
        k = cls(o);
        for (int i = 0; i <= wf; i++) begin
            e = base(4'd0); e.rd = 1'b1; e.src_b = 2'b01;
            if (i == wf) begin e.irw = 1'b1; e.pc_en = 1'b1; end
            add(e, (i == wf), 6'($urandom), 1'($urandom));
        end
        e = base(4'd1); e.src_b = 2'b11; e.ill = (k == c_ILL);
        add(e, 1'($urandom), o, 1'($urandom));
        case (k)
            c_R: begin
                e = base(4'd6); e.src_a = 1'b1; e.alu_op = 6'b000000; add_any(e);
                e = base(4'd7); e.rw = 1'b1; e.rdst = 1'b1; add_any(e);
            end
            c_LD, c_ST: begin
                e = base(4'd2); e.src_a = 1'b1; e.src_b = 2'b10; e.alu_op = o; add_any(e);
                for (int i = 0; i <= wm; i++) begin
                    e = base((k == c_LD) ? 4'd3 : 4'd5); e.i_or_d = 1'b1;
                    if (k == c_LD) e.rd = 1'b1; else e.wr = 1'b1;
                    e.byt = (o == 6'b100000) || (o == 6'b101000);
                    add(e, (i == wm), 6'($urandom), 1'($urandom));
                end
                if (k == c_LD) begin
                    e = base(4'd4); e.rw = 1'b1; e.m2r = 1'b1; add_any(e);
                end
            end
            c_IMM: begin
                e = base(4'd9); e.src_a = 1'b1; e.src_b = 2'b10; e.alu_op = o; add_any(e);
                e = base(4'd10); e.rw = 1'b1; add_any(e);
            end
            c_BR: begin
                z = 1'($urandom);
                e = base(4'd8); e.src_a = 1'b1; e.alu_op = o; e.pc_src = 2'b01;
                e.pc_en = (o == 6'b000100) ? z : ~z;
                add(e, 1'($urandom), 6'($urandom), z);
            end
            c_J: begin
                e = base(4'd11); e.pc_en = 1'b1; e.pc_src = 2'b10; add_any(e);
            end
            default: ;
        endcase
    endtask

    task automatic run_trace(input string nm);
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            opcode = c.opc; zero = c.z; mem_bus.mem_ready = c.rdy;
            #1;
            chk(nm, 32'(got), 32'(c.e));
            @(negedge clk);
        end
    endtask

    // Runs one instruction from FETCH back to FETCH, counting cycles and strobes.
    task automatic run_vec(input int idx);
        vec_t v;
        int   fc = 0, mc = 0, nrw = 0, nmw = 0, npc = 0, nil = 0, cyc = 0;
        bit   left = 0, done = 0;
        v = vecs[idx];
        for (int k = 1; k <= 40 && !done; k++) begin
            opcode = v.opc; zero = v.z;
            if (state == 4'd0) begin
                mem_bus.mem_ready = (fc >= v.wf); fc++;
            end else if (state == 4'd3 || state == 4'd5) begin
                mem_bus.mem_ready = (mc >= v.wm); mc++;
            end else begin
                mem_bus.mem_ready = 1'b1;
            end
            #1;
            nrw += int'(reg_write); nmw += int'(mem_bus.mem_write);
            npc += int'(pc_en);     nil += int'(illegal_op);
            @(negedge clk);
            if (state != 4'd0) left = 1;
            else if (left) begin done = 1; cyc = k; end
        end
        chk($sformatf("vec%0d_cycles", idx), 32'(cyc),   32'(v.cyc));
        chk($sformatf("vec%0d_regwr", idx),  32'(nrw),   32'(v.nrw));
        chk($sformatf("vec%0d_memwr", idx),  32'(nmw),   32'(v.nmw));
        chk($sformatf("vec%0d_pcen", idx),   32'(npc),   32'(v.npc));
        chk($sformatf("vec%0d_illegal", idx), 32'(nil),  32'(v.nill));
        if (!done) begin
            rst = 1'b1; #1; rst = 1'b0;
        end
    endtask

    // Walk to a target state, then assert rst between clock edges.
    task automatic reset_mid(input string nm, input logic [5:0] o, input logic [3:0] tgt,
                             input logic [1:0] pre_exp);
        int n = 0;
        while (state != tgt && n < 12) begin
            opcode = o; zero = 1'b0; mem_bus.mem_ready = (state == 4'd0);
            #1;
            @(negedge clk);
            n++;
        end
        chk({nm, "_reach"}, 32'(state), 32'(tgt));
        opcode = o; mem_bus.mem_ready = 1'b0;
        #1;
        chk({nm, "_pre"}, 32'({reg_write, mem_bus.mem_write}), 32'(pre_exp));
        #2 rst = 1'b1;
        #1;
        chk({nm, "_abort"}, 32'({state, reg_write, mem_bus.mem_write}), 32'(6'b000000));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk({nm, "_restart"}, 32'({state, mem_bus.mem_read, mem_bus.i_or_d}), 32'(6'b000010));
        @(negedge clk);
    endtask

    initial begin
        outv_t e;
        logic [5:0] o;
        int idx;

        //            opc        z     wf wm cyc rw mw pc ill
        vecs[0]  = '{6'b000000, 1'b0, 0, 0, 4, 1, 0, 1, 0};
        vecs[1]  = '{6'b100011, 1'b0, 0, 2, 7, 1, 0, 1, 0};
        vecs[2]  = '{6'b100000, 1'b0, 1, 0, 6, 1, 0, 1, 0};
        vecs[3]  = '{6'b101011, 1'b0, 0, 1, 5, 0, 2, 1, 0};
        vecs[4]  = '{6'b101000, 1'b1, 0, 0, 4, 0, 1, 1, 0};
        vecs[5]  = '{6'b001000, 1'b0, 0, 0, 4, 1, 0, 1, 0};
        vecs[6]  = '{6'b001101, 1'b1, 2, 0, 6, 1, 0, 1, 0};
        vecs[7]  = '{6'b001010, 1'b0, 0, 0, 4, 1, 0, 1, 0};
        vecs[8]  = '{6'b000100, 1'b1, 0, 0, 3, 0, 0, 2, 0};
        vecs[9]  = '{6'b000100, 1'b0, 0, 0, 3, 0, 0, 1, 0};
        vecs[10] = '{6'b000101, 1'b1, 0, 0, 3, 0, 0, 1, 0};
        vecs[11] = '{6'b000101, 1'b0, 0, 0, 3, 0, 0, 2, 0};
        vecs[12] = '{6'b111111, 1'b0, 0, 0, 2, 0, 0, 1, 1};
        vecs[13] = '{6'b001100, 1'b0, 0, 0, 4, 1, 0, 1, 0};
`ifdef MIPS_CTRL_JUMP_EN
        vecs[14] = '{6'b000010, 1'b0, 0, 0, 3, 0, 0, 2, 0};
`else
        vecs[14] = '{6'b000010, 1'b0, 0, 0, 2, 0, 0, 1, 1};
`endif
        ops = '{6'b000000, 6'b100011, 6'b100000, 6'b101011, 6'b101000, 6'b001000, 6'b001100,
                6'b001101, 6'b001010, 6'b000100, 6'b000101, 6'b000010, 6'b111111, 6'b010101};

        rst = 1'b1; opcode = 6'b000000; zero = 1'b0; mem_bus.mem_ready = 1'b0;
        @(negedge clk);
        #1;
        e = base(4'd0); e.rd = 1'b1; e.src_b = 2'b01;
        chk("reset_outputs", 32'(got), 32'(e));
        @(negedge clk);
        rst = 1'b0;
        #1;
        @(negedge clk);
        chk("reset_release_state", 32'(state), 32'(4'd0));

        for (int i = 0; i < 15; i++) run_vec(i);

        reset_mid("rst_in_rwb", 6'b000000, 4'd7, 2'b10);
        reset_mid("rst_in_memwrite", 6'b101011, 4'd5, 2'b01);

        // Directed trace: lw with two wait states, matching the expected 0,1,2,3,3,3,4 walk.
        build(6'b100011, 0, 2);
        run_trace("trace_lw");

        for (int n = 0; n < 200; n++) begin
            idx = $urandom_range(0, 14);
            o   = (idx == 14) ? 6'($urandom) : ops[idx];
            build(o, $urandom_range(0, 2), $urandom_range(0, 3));
            run_trace($sformatf("rand%0d_op%b", n, o));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
